// File: rtl/mmc_cmd_frame_tx.sv
// mmc_cmd_frame_tx: parametrised MMC command frame serialiser.
// Sends data_i[FRAME_W-1:CRC_W+1] MSB-first on the bit clock falling edge,
// then the generated CRC, then the end bit, then GAP_BITS idle bit periods.
// Optional build macro MMC_CMD_TX_COLLISION_EN adds pad readback (cmd_i)
// and aborts the frame on open-drain contention (collision_o pulse).
//
// state | meaning
// IDLE  | ready for start_i
// WAIT  | payload captured, waiting for first bit clock falling edge
// DATA  | shifting out start/transmit/payload bits, CRC accumulating
// CRC   | shifting out CRC bits, MSB first
// END   | next strobe drives the end bit and latches crc_o
// GAP   | line released, counting idle bit periods, then complete_o
module mmc_cmd_frame_tx #(
    parameter int unsigned      FRAME_W  = 48,
    parameter int unsigned      CRC_W    = 7,
    parameter logic [CRC_W-1:0] CRC_POLY = 7'h09,
    parameter int unsigned      GAP_BITS = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               bitclk_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [FRAME_W-1:0] data_i,
`ifdef MMC_CMD_TX_COLLISION_EN
    input  logic               cmd_i,
    output logic               collision_o,
`endif
    output logic               ready_o,
    output logic               active_o,
    output logic               cmd_o,
    output logic               cmd_oe_o,
    output logic               complete_o,
    output logic [CRC_W-1:0]   crc_o
);

    localparam int unsigned PAY_W = FRAME_W - CRC_W - 1;
    localparam int unsigned IDX_W = $clog2(FRAME_W);
    localparam int unsigned GAP_W = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;

    typedef enum logic [2:0] {IDLE, WAIT, DATA, CRC, END, GAP} state_t;

    state_t             state_q;
    logic               bclk_q;
    logic [PAY_W-1:0]   shift_q;
    logic [CRC_W-1:0]   crc_q;
    logic [CRC_W-1:0]   crc_d;
    logic [CRC_W-1:0]   crc_out_q;
    logic [IDX_W-1:0]   idx_q;
    logic [GAP_W-1:0]   gap_q;
    logic               cmd_q;
    logic               oe_q;
    logic               cpl_q;
    logic               drive;
    logic               crc_bit;
    logic               kill;
    logic               unused_low_bits;

    // CRC and end-bit positions of data_i are regenerated internally
    assign unused_low_bits = ^data_i[CRC_W:0];

    assign drive = ~bitclk_i & bclk_q;

`ifdef MMC_CMD_TX_COLLISION_EN
    logic sample;
    logic collide;
    logic coll_q;
    assign sample      = bitclk_i & ~bclk_q;
    // a driven 1 read back as 0 means another card is pulling the line low
    assign collide     = sample & (state_q == DATA) & cmd_q & ~cmd_i;
    assign kill        = abort_i | collide;
    assign collision_o = coll_q;

    // one-cycle collision indication, cleared on every other cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) coll_q <= 1'b0;
        else       coll_q <= collide;
    end
`else
    assign kill = abort_i;
`endif

    // serial LFSR step on the bit currently leaving the shift register
    always_comb begin
        crc_d = {crc_q[CRC_W-2:0], 1'b0};
        if (shift_q[PAY_W-1] ^ crc_q[CRC_W-1]) crc_d = crc_d ^ CRC_POLY;
    end

    // select CRC bit idx_q-1 (idx_q runs CRC_W down to 1 in CRC state)
    always_comb begin
        crc_bit = 1'b0;
        for (int i = 0; i < CRC_W; i++) begin
            if (idx_q == IDX_W'(i + 1)) crc_bit = crc_q[i];
        end
    end

    // bit clock history for edge strobes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) bclk_q <= 1'b0;
        else       bclk_q <= bitclk_i;
    end

    // frame sequencer with registered line outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            crc_q     <= '0;
            crc_out_q <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            cmd_q     <= 1'b1;
            oe_q      <= 1'b0;
            cpl_q     <= 1'b0;
        end else begin
            cpl_q <= 1'b0;
            if (kill) begin
                state_q <= IDLE;
                cmd_q   <= 1'b1;
                oe_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start_i) begin
                        shift_q <= data_i[FRAME_W-1:CRC_W+1];
                        crc_q   <= '0;
                        idx_q   <= IDX_W'(FRAME_W - 1);
                        state_q <= WAIT;
                    end
                    WAIT, DATA: if (drive) begin
                        cmd_q   <= shift_q[PAY_W-1];
                        oe_q    <= 1'b1;
                        shift_q <= {shift_q[PAY_W-2:0], 1'b0};
                        crc_q   <= crc_d;
                        idx_q   <= idx_q - 1'b1;
                        state_q <= (idx_q == IDX_W'(CRC_W + 1)) ? CRC : DATA;
                    end
                    CRC: if (drive) begin
                        cmd_q <= crc_bit;
                        idx_q <= idx_q - 1'b1;
                        if (idx_q == IDX_W'(1)) state_q <= END;
                    end
                    END: if (drive) begin
                        cmd_q     <= 1'b1;
                        crc_out_q <= crc_q;
                        gap_q     <= GAP_W'(GAP_BITS);
                        state_q   <= GAP;
                    end
                    GAP: begin
                        if (cpl_q) begin
                            state_q <= IDLE;
                        end else if (drive) begin
                            cmd_q <= 1'b1;
                            oe_q  <= 1'b0;
                            if (gap_q == '0) cpl_q <= 1'b1;
                            else             gap_q <= gap_q - 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ready_o    = (state_q == IDLE);
    assign active_o   = (state_q != IDLE);
    assign cmd_o      = cmd_q;
    assign cmd_oe_o   = oe_q;
    assign complete_o = cpl_q;
    assign crc_o      = crc_out_q;

endmodule
